// File: rtl/axis_os_sa_pkg.sv
// axis_os_sa_pkg: shared FSM state type and arithmetic helpers for the output-stationary systolic array.
package axis_os_sa_pkg;
  typedef enum logic [1:0] {ACCEPT, FLUSH, DRAIN} sa_state_e;
  function automatic int flush_cycles(int rows, int cols);
    return rows + cols - 1;
  endfunction
  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed w-bit range.
  function automatic logic signed [63:0] sat_add(logic signed [63:0] a, logic signed [63:0] b, int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/os_sa_pe.sv
// os_sa_pe: one processing element; forwards x right and k down, accumulates sext(x*k) on valid beats.
// AXIS_OS_SA_SATURATE_EN selects a saturating accumulator instead of wrap-around.
module os_sa_pe
  import axis_os_sa_pkg::*;
#(
  parameter int WidthX = 8,
  parameter int WidthK = 8,
  parameter int WidthY = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WidthX-1:0] x_i,
  input  logic [WidthK-1:0] k_i,
  input  logic              v_i,
  input  logic              f_i,
  output logic [WidthX-1:0] x_o,
  output logic [WidthK-1:0] k_o,
  output logic              v_o,
  output logic              f_o,
  output logic [WidthY-1:0] acc_o
);
  logic signed [WidthX+WidthK-1:0] prod;
  logic signed [WidthY-1:0] pext, acc_q, sum;
  assign prod = $signed(x_i) * $signed(k_i);
  assign pext = WidthY'(prod);
`ifdef AXIS_OS_SA_SATURATE_EN
  assign sum = WidthY'(sat_add(64'(acc_q), 64'(pext), WidthY));
`else
  assign sum = acc_q + pext;
`endif
  assign acc_o = acc_q;
  // f_i marks the first beat of a fresh packet: the product replaces the old sum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_o   <= '0;
      k_o   <= '0;
      v_o   <= 1'b0;
      f_o   <= 1'b0;
      acc_q <= '0;
    end else begin
      x_o <= x_i;
      k_o <= k_i;
      v_o <= v_i;
      f_o <= f_i;
      if (v_i) acc_q <= f_i ? pext : sum;
    end
  end
endmodule

// File: rtl/axis_os_sa.sv
// axis_os_sa: output-stationary integer systolic array, AXI-Stream beats in, one column of Y per output beat.
// Define AXIS_OS_SA_SATURATE_EN for saturating accumulation; default is two's-complement wrap.
module axis_os_sa
  import axis_os_sa_pkg::*;
#(
  parameter int Rows   = 2,
  parameter int Cols   = 4,
  parameter int WidthX = 8,
  parameter int WidthK = 8,
  parameter int WidthY = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic                   s_last_i,
  input  logic                   s_acc_i,
  input  logic [Rows*WidthX-1:0] sx_data_i,
  input  logic [Cols*WidthK-1:0] sk_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  output logic [Rows*WidthY-1:0] m_data_o
);
  localparam int FC = flush_cycles(Rows, Cols);
  localparam int FW = $clog2(FC + 1);
  localparam int CW = (Cols > 1) ? $clog2(Cols) : 1;

  sa_state_e state_q, state_d;
  logic [FW-1:0] cnt_q;
  logic [CW-1:0] col_ptr_q;
  logic first_q, hs, clr, last_col;
  logic [WidthX-1:0] x_m [Rows][Cols+1];
  logic v_m [Rows][Cols+1];
  logic f_m [Rows][Cols+1];
  logic [WidthK-1:0] k_m [Rows+1][Cols];
  logic [WidthY-1:0] acc_m [Rows][Cols];
  logic [Rows-1:0] unused_x;
  logic [Cols-1:0] unused_k;

  assign hs       = s_valid_i & s_ready_o;
  assign clr      = first_q & ~s_acc_i;
  assign last_col = col_ptr_q == CW'(Cols - 1);

  // Row lane r: input stage plus r skew registers; valid and clear flag ride with x.
  for (genvar r = 0; r < Rows; r++) begin : g_row
    logic [WidthX-1:0] xd [r+1];
    logic vd [r+1];
    logic fd [r+1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i <= r; i++) begin
          xd[i] <= '0;
          vd[i] <= 1'b0;
          fd[i] <= 1'b0;
        end
      end else begin
        xd[0] <= sx_data_i[r*WidthX +: WidthX];
        vd[0] <= hs;
        fd[0] <= hs & clr;
        for (int i = 1; i <= r; i++) begin
          xd[i] <= xd[i-1];
          vd[i] <= vd[i-1];
          fd[i] <= fd[i-1];
        end
      end
    end
    assign x_m[r][0] = xd[r];
    assign v_m[r][0] = vd[r];
    assign f_m[r][0] = fd[r];
    assign unused_x[r] = ^{x_m[r][Cols], v_m[r][Cols], f_m[r][Cols]};
  end

  for (genvar c = 0; c < Cols; c++) begin : g_col
    logic [WidthK-1:0] kd [c+1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i <= c; i++) kd[i] <= '0;
      end else begin
        kd[0] <= sk_data_i[c*WidthK +: WidthK];
        for (int i = 1; i <= c; i++) kd[i] <= kd[i-1];
      end
    end
    assign k_m[0][c] = kd[c];
    assign unused_k[c] = ^k_m[Rows][c];
  end

  for (genvar r = 0; r < Rows; r++) begin : g_mr
    for (genvar c = 0; c < Cols; c++) begin : g_mc
      os_sa_pe #(.WidthX(WidthX), .WidthK(WidthK), .WidthY(WidthY)) u_pe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .x_i   (x_m[r][c]),
        .k_i   (k_m[r][c]),
        .v_i   (v_m[r][c]),
        .f_i   (f_m[r][c]),
        .x_o   (x_m[r][c+1]),
        .k_o   (k_m[r+1][c]),
        .v_o   (v_m[r][c+1]),
        .f_o   (f_m[r][c+1]),
        .acc_o (acc_m[r][c])
      );
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACCEPT;
    else state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        s_ready_o = 1'b1;
        state_d   = (s_valid_i && s_last_i) ? FLUSH : ACCEPT;
      end
      FLUSH: state_d = (cnt_q == FW'(FC - 1)) ? DRAIN : FLUSH;
      DRAIN: begin
        m_valid_o = 1'b1;
        m_last_o  = last_col;
        state_d   = (m_ready_i && last_col) ? ACCEPT : DRAIN;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // The flush counter lets the final beat ripple through to the far corner PE before draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      col_ptr_q <= '0;
      first_q   <= 1'b1;
    end else begin
      cnt_q <= (state_q == FLUSH) ? cnt_q + FW'(1) : '0;
      if (m_valid_o && m_ready_i) col_ptr_q <= last_col ? '0 : col_ptr_q + CW'(1);
      if (hs) first_q <= s_last_i;
    end
  end

  always_comb begin
    m_data_o = '0;
    for (int r = 0; r < Rows; r++) m_data_o[r*WidthY +: WidthY] = m_valid_o ? acc_m[r][col_ptr_q] : '0;
  end
endmodule

// File: tb/tb_axis_os_sa.sv
// tb_axis_os_sa: directed packets with hand-computed Y, scoreboard queues checked by per-DUT output monitors.
module tb_axis_os_sa;
  localparam int Rows = 2;
  localparam int Cols = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic s_valid = 1'b0, s_last = 1'b0, s_acc = 1'b0, m_ready = 1'b1, sel16 = 1'b0, alt = 1'b0;
  logic [15:0] sx = '0;
  logic [31:0] sk = '0;
  logic va, vb, ra, rb, mva, mvb, mla, mlb;
  logic [63:0] mda;
  logic [31:0] mdb;
  int nvec = 0, nerr = 0, cyc = 0, e0 = 0;
  logic [64:0] qa[$];
  logic [32:0] qb[$];

  assign va = s_valid & ~sel16;
  assign vb = s_valid & sel16;

  axis_os_sa #(.Rows(2), .Cols(4), .WidthX(8), .WidthK(8), .WidthY(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(va), .s_ready_o(ra), .s_last_i(s_last), .s_acc_i(s_acc),
    .sx_data_i(sx), .sk_data_i(sk), .m_valid_o(mva), .m_ready_i(m_ready), .m_last_o(mla), .m_data_o(mda)
  );

  axis_os_sa #(.Rows(2), .Cols(4), .WidthX(8), .WidthK(8), .WidthY(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(vb), .s_ready_o(rb), .s_last_i(s_last), .s_acc_i(s_acc),
    .sx_data_i(sx), .sk_data_i(sk), .m_valid_o(mvb), .m_ready_i(m_ready), .m_last_o(mlb), .m_data_o(mdb)
  );

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = alt ? ~m_ready : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic pva = 1'b0, hela = 1'b0, pvb = 1'b0, helb = 1'b0;
  logic [64:0] hda;
  logic [32:0] hdb;

  always @(negedge clk) begin
    if (mva && !pva) chk("latency_a", 128'(cyc - e0), 128'd5);
    if (mva) begin
      chk("s_ready_low_a", 128'(ra), 128'd0);
      if (hela) chk("hold_a", 128'({mla, mda}), 128'(hda));
      hela = ~m_ready;
      hda  = {mla, mda};
      if (m_ready) begin
        if (qa.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_beat_a: got %0h want none", {mla, mda});
        end else chk("beat_a", 128'({mla, mda}), 128'(qa.pop_front()));
      end
    end else hela = 1'b0;
    pva = mva;
  end

  always @(negedge clk) begin
    if (mvb && !pvb) chk("latency_b", 128'(cyc - e0), 128'd5);
    if (mvb) begin
      chk("s_ready_low_b", 128'(rb), 128'd0);
      if (helb) chk("hold_b", 128'({mlb, mdb}), 128'(hdb));
      helb = ~m_ready;
      hdb  = {mlb, mdb};
      if (m_ready) begin
        if (qb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_beat_b: got %0h want none", {mlb, mdb});
        end else chk("beat_b", 128'({mlb, mdb}), 128'(qb.pop_front()));
      end
    end else helb = 1'b0;
    pvb = mvb;
  end

  task automatic send(input int n, input logic [7:0] x, input logic [7:0] k, input logic acc,
                      input logic bub, input logic w16, input logic [31:0] y);
    int t;
    for (int c = 0; c < Cols; c++) begin
      if (w16) qb.push_back({c == Cols - 1, {Rows{y[15:0]}}});
      else qa.push_back({c == Cols - 1, {Rows{y}}});
    end
    sel16 = w16;
    for (int i = 0; i < n; i++) begin
      if (bub) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      sx      = {Rows{x}};
      sk      = {Cols{k}};
      s_last  = (i == n - 1);
      s_acc   = (i == 0) ? acc : ~acc;
      t = 0;
      while (!(w16 ? rb : ra) && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t == 100) begin
        nvec++;
        nerr++;
        $display("FAIL ready_timeout: got s_ready=0 want 1");
      end
      @(posedge clk);
      #1;
    end
    e0      = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 300) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", qa.size() + qb.size());
    end
    chk("idle_a", 128'({ra, mva, mla}), 128'(3'b100));
    chk("idle_b", 128'({rb, mvb, mlb}), 128'(3'b100));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    chk("rst_a", 128'({ra, mva, mla, mda}), 128'({1'b1, 1'b0, 1'b0, 64'h0}));
    chk("rst_b", 128'({rb, mvb, mlb, mdb}), 128'({1'b1, 1'b0, 1'b0, 32'h0}));
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_rst();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    wait_done();
    send(8, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 32'd131072);
    wait_done();
    send(8, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8);
    wait_done();
    alt = 1'b1;
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    wait_done();
    alt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(4, 8'd1, 8'd2, 1'b0, 1'b1, 1'b0, 32'd8);
    wait_done();
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    wait_done();
    send(4, 8'd1, 8'd2, 1'b1, 1'b0, 1'b0, 32'd16);
    wait_done();
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    wait_done();
`ifdef AXIS_OS_SA_SATURATE_EN
    send(8, 8'd127, 8'd127, 1'b0, 1'b0, 1'b1, 32'h0000_7FFF);
`else
    send(8, 8'd127, 8'd127, 1'b0, 1'b0, 1'b1, 32'h0000_F808);
`endif
    wait_done();
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    t = 0;
    while (!(qa.size() == 3 && mva) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 100) begin
      nvec++;
      nerr++;
      $display("FAIL drain_beat2_timeout: got %0d pending want 3", qa.size());
    end
    rst_n = 1'b0;
    #1;
    check_rst();
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    check_rst();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 32'd8);
    wait_done();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
